// File: rtl/frame_sync_ctrl.sv
// Frame-level handshake between the game CPU and the VGA controller. Coordinates are committed
// to the display shadow registers only on frame boundaries. Also debounces the jump button.
module frame_sync_ctrl #(
  parameter int unsigned COORD_W         = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               cpu_done,
  input  logic               button_raw,
  input  logic [COORD_W-1:0] cpu_x_dino,
  input  logic [COORD_W-1:0] cpu_y_dino,
  input  logic [COORD_W-1:0] cpu_x_obs,
  input  logic [COORD_W-1:0] cpu_y_obs,
  output logic               screen_ready,
  output logic [COORD_W-1:0] disp_x_dino,
  output logic [COORD_W-1:0] disp_y_dino,
  output logic [COORD_W-1:0] disp_x_obs,
  output logic [COORD_W-1:0] disp_y_obs,
  output logic               button_press,
  output logic               button_pulse,
  output logic [15:0]        frame_count,
  output logic [7:0]         missed_frames
);

  localparam int unsigned SetW = 4 * COORD_W;
  localparam logic [CNT_W-1:0] DbMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e            state_q, state_d;
  logic [SetW-1:0]   cpu_set;
  logic [SetW-1:0]   pend_q, pend_d;
  logic [SetW-1:0]   disp_q, disp_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [7:0]        missed_q, missed_d;
  logic              screen_ready_q, screen_ready_d;

  logic              done_s1_q, done_s2_q, done_prev_q;
  logic              done_rise;
  logic              btn_s1_q, btn_s2_q;
  logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
  logic              press_q, press_d;
  logic              pulse_q, pulse_d;

  assign cpu_set   = {cpu_x_dino, cpu_y_dino, cpu_x_obs, cpu_y_obs};
  assign done_rise = done_s2_q & ~done_prev_q;

  // Two-flop synchronizers plus the edge-detect history flop for cpu_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_s1_q   <= 1'b0;
      done_s2_q   <= 1'b0;
      done_prev_q <= 1'b0;
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
    end else begin
      done_s1_q   <= cpu_done;
      done_s2_q   <= done_s1_q;
      done_prev_q <= done_s2_q;
      btn_s1_q    <= button_raw;
      btn_s2_q    <= btn_s1_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    disp_d        = disp_q;
    frame_count_d = frame_count_q;
    missed_d      = missed_q;
    unique case (state_q)
      StIdle: begin
        if (frame_tick) state_d = StReq;
      end
      StReq: begin
        if (frame_tick && done_rise) begin
          // CPU finished exactly on the boundary: commit directly, skip pending.
          disp_d        = cpu_set;
          frame_count_d = frame_count_q + 16'd1;
        end else if (frame_tick) begin
          if (missed_q != 8'hFF) missed_d = missed_q + 8'd1;
        end else if (done_rise) begin
          pend_d  = cpu_set;
          state_d = StHold;
        end
      end
      StHold: begin
        if (frame_tick) begin
          disp_d        = pend_q;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
    screen_ready_d = (state_d == StReq);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      pend_q         <= '0;
      disp_q         <= '0;
      frame_count_q  <= '0;
      missed_q       <= '0;
      screen_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      disp_q         <= disp_d;
      frame_count_q  <= frame_count_d;
      missed_q       <= missed_d;
      screen_ready_q <= screen_ready_d;
    end
  end

  // Debounce: any disagreement must persist DEBOUNCE_CYCLES cycles before the output follows.
  always_comb begin
    db_cnt_d = db_cnt_q;
    press_d  = press_q;
    pulse_d  = 1'b0;
    if (btn_s2_q == press_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbMax) begin
      db_cnt_d = '0;
      press_d  = btn_s2_q;
      pulse_d  = btn_s2_q;
    end else begin
      db_cnt_d = db_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q <= '0;
      press_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      pulse_q  <= pulse_d;
    end
  end

  assign screen_ready  = screen_ready_q;
  assign disp_x_dino   = disp_q[SetW-1 -: COORD_W];
  assign disp_y_dino   = disp_q[3*COORD_W-1 -: COORD_W];
  assign disp_x_obs    = disp_q[2*COORD_W-1 -: COORD_W];
  assign disp_y_obs    = disp_q[COORD_W-1:0];
  assign frame_count   = frame_count_q;
  assign missed_frames = missed_q;
  assign button_press  = press_q;
  assign button_pulse  = pulse_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed bench for frame_sync_ctrl: cycle table for the frame handshake, then hand-written
// sequences for miss saturation, reset in HOLD and button debounce.
module tb_frame_sync_ctrl;

  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          reset, frame_tick, cpu_done, button_raw;
  logic [CW-1:0] cpu_x_dino, cpu_y_dino, cpu_x_obs, cpu_y_obs;
  logic          screen_ready, button_press, button_pulse;
  logic [CW-1:0] disp_x_dino, disp_y_dino, disp_x_obs, disp_y_obs;
  logic [15:0]   frame_count;
  logic [7:0]    missed_frames;

  int n_cmp = 0;
  int n_err = 0;

  frame_sync_ctrl #(
    .COORD_W        (CW),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .cpu_done     (cpu_done),
    .button_raw   (button_raw),
    .cpu_x_dino   (cpu_x_dino),
    .cpu_y_dino   (cpu_y_dino),
    .cpu_x_obs    (cpu_x_obs),
    .cpu_y_obs    (cpu_y_obs),
    .screen_ready (screen_ready),
    .disp_x_dino  (disp_x_dino),
    .disp_y_dino  (disp_y_dino),
    .disp_x_obs   (disp_x_obs),
    .disp_y_obs   (disp_y_obs),
    .button_press (button_press),
    .button_pulse (button_pulse),
    .frame_count  (frame_count),
    .missed_frames(missed_frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         tick;
    logic         done;
    logic [127:0] coords;
    logic         sr;
    logic [127:0] disp;
    logic [15:0]  fc;
    logic [7:0]   miss;
  } vec_t;

  vec_t vecs[$];

  localparam logic [127:0] Z  = 128'd0;
  localparam logic [127:0] C1 = {32'd100, 32'd200, 32'd600, 32'd200};
  localparam logic [127:0] C2 = {32'd5, 32'd6, 32'd7, 32'd8};
  localparam logic [127:0] C9 = {32'd9, 32'd9, 32'd9, 32'd9};

  task automatic add(input logic rst, input logic tick, input logic done,
                     input logic [127:0] coords, input logic sr, input logic [127:0] disp,
                     input logic [15:0] fc, input logic [7:0] miss);
    vec_t v;
    v.rst = rst; v.tick = tick; v.done = done; v.coords = coords;
    v.sr = sr; v.disp = disp; v.fc = fc; v.miss = miss;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] disp_all();
    return {disp_x_dino, disp_y_dino, disp_x_obs, disp_y_obs};
  endfunction

  task automatic set_coords(input logic [127:0] c);
    {cpu_x_dino, cpu_y_dino, cpu_x_obs, cpu_y_obs} = c;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; cpu_done = 1'b0; button_raw = 1'b0;
    set_coords(Z);

    // rst tick done coords | screen_ready disp frame_count missed
    add(1, 0, 0, Z,  0, Z,  0, 0);
    add(1, 0, 0, Z,  0, Z,  0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, Z, 0, Z, 0, 0);
    add(0, 1, 0, Z,  1, Z,  0, 0);
    add(0, 0, 0, C1, 1, Z,  0, 0);
    add(0, 0, 1, C1, 1, Z,  0, 0);
    add(0, 0, 1, C1, 1, Z,  0, 0);
    add(0, 0, 1, C1, 0, Z,  0, 0);
    add(0, 0, 1, C1, 0, Z,  0, 0);
    add(0, 1, 1, C1, 1, C1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, C1, 1, C1, 1, 0);
    add(0, 1, 0, C1, 1, C1, 1, 1);
    add(0, 0, 0, C1, 1, C1, 1, 1);
    add(0, 1, 0, C1, 1, C1, 1, 2);
    add(0, 1, 0, C1, 1, C1, 1, 3);
    // done_rise coincides with frame_tick
    add(0, 0, 1, C2, 1, C1, 1, 3);
    add(0, 0, 1, C2, 1, C1, 1, 3);
    add(0, 1, 1, C2, 1, C2, 2, 3);
    add(0, 0, 1, C2, 1, C2, 2, 3);
    add(0, 1, 1, C2, 1, C2, 2, 4);
    // capture C1, then a second rise while in HOLD must not replace pending
    add(0, 0, 0, C2, 1, C2, 2, 4);
    add(0, 0, 0, C2, 1, C2, 2, 4);
    add(0, 0, 1, C1, 1, C2, 2, 4);
    add(0, 0, 1, C1, 1, C2, 2, 4);
    add(0, 0, 1, C1, 0, C2, 2, 4);
    for (int i = 0; i < 3; i++) add(0, 0, 0, C1, 0, C2, 2, 4);
    for (int i = 0; i < 4; i++) add(0, 0, 1, C2, 0, C2, 2, 4);
    add(0, 1, 1, C2, 1, C1, 3, 4);

    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; frame_tick = vecs[i].tick; cpu_done = vecs[i].done;
      set_coords(vecs[i].coords);
      step();
      check($sformatf("row%0d screen_ready", i), 128'(screen_ready), 128'(vecs[i].sr));
      check($sformatf("row%0d disp", i), disp_all(), vecs[i].disp);
      check($sformatf("row%0d frame_count", i), 128'(frame_count), 128'(vecs[i].fc));
      check($sformatf("row%0d missed_frames", i), 128'(missed_frames), 128'(vecs[i].miss));
    end

    // missed_frames saturation: 4 already, 300 more ticks in REQ
    frame_tick = 1'b0; cpu_done = 1'b0;
    for (int i = 0; i < 3; i++) step();
    frame_tick = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 250) check("missed at 254", 128'(missed_frames), 128'(8'd254));
      if (i == 251) check("missed reaches 255", 128'(missed_frames), 128'(8'd255));
    end
    frame_tick = 1'b0;
    check("missed saturated", 128'(missed_frames), 128'(8'd255));
    check("disp after misses", disp_all(), C1);
    check("frame_count after misses", 128'(frame_count), 128'(16'd3));

    // reset while in HOLD with pending (9,9,9,9)
    set_coords(C9); cpu_done = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("hold before reset", 128'(screen_ready), 128'(1'b0));
    reset = 1'b1; cpu_done = 1'b0;
    step();
    check("reset screen_ready", 128'(screen_ready), 128'(1'b0));
    check("reset disp", disp_all(), Z);
    check("reset frame_count", 128'(frame_count), 128'(16'd0));
    check("reset missed", 128'(missed_frames), 128'(8'd0));
    check("reset button_press", 128'(button_press), 128'(1'b0));
    check("reset button_pulse", 128'(button_pulse), 128'(1'b0));
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("idle after reset", 128'(screen_ready), 128'(1'b0));
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("req after reset", 128'(screen_ready), 128'(1'b1));
    check("disp after reset tick", disp_all(), Z);
    check("frame_count after reset tick", 128'(frame_count), 128'(16'd0));
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("pending discarded disp", disp_all(), Z);
    check("pending discarded missed", 128'(missed_frames), 128'(8'd1));

    // debounce: short glitch never propagates
    begin
      logic [5:0] glitch;
      glitch = 6'b000101;
      for (int i = 0; i < 6; i++) begin
        button_raw = glitch[i];
        step();
        check($sformatf("glitch%0d press", i), 128'(button_press), 128'(1'b0));
        check($sformatf("glitch%0d pulse", i), 128'(button_pulse), 128'(1'b0));
      end
    end
    button_raw = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("glitch settled press", 128'(button_press), 128'(1'b0));

    button_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("hold%0d press", k), 128'(button_press), 128'(k >= 10));
      check($sformatf("hold%0d pulse", k), 128'(button_pulse), 128'(k == 10));
    end
    button_raw = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("release%0d press", k), 128'(button_press), 128'(k < 10));
      check($sformatf("release%0d pulse", k), 128'(button_pulse), 128'(1'b0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
